// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states and owner codes.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way pick: round-robin against last_owner, or D-wins when FIXED_PRI=1.
module arb_pick2
   import mem_arb_pkg::*;
#(
   parameter int FIXED_PRI = 0
) (
   input  logic i_req,
   input  logic d_req,
   input  logic last_owner,
   output logic winner
);

   always_comb begin
      winner = OWN_I;
      if (i_req && d_req) begin
         if (FIXED_PRI != 0) winner = OWN_D;
         else                winner = (last_owner == OWN_I) ? OWN_D : OWN_I;
      end else if (d_req) begin
         winner = OWN_D;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch (I) and load/store (D) onto one memory port, sequencing IDLE->BUSY->DONE.
// Optional BUSY timeout with err pulse is built when ARB_TIMEOUT_EN is defined.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int FIXED_PRI   = 0,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_done,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_done,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ack,
`ifdef ARB_TIMEOUT_EN
   output logic          err,
`endif
   output logic          sel
);

   arb_state_t    state_q, state_d;
   logic          sel_q, sel_d;
   logic          last_q, last_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          winner;
   logic          timeout;

   arb_pick2 #(.FIXED_PRI(FIXED_PRI)) u_pick (
      .i_req      (i_req),
      .d_req      (d_req),
      .last_owner (last_q),
      .winner     (winner)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;

   assign timeout = (state_q == BUSY) && (cnt_q == CW'(TIMEOUT_CYC - 1)) && !mem_ack;

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (state_q == IDLE) begin
         cnt_d = '0;
         err_d = 1'b0;
      end else if (state_q == BUSY) begin
         cnt_d = cnt_q + 1'b1;
         err_d = timeout;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err = (state_q == DONE) && err_q;
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      last_d  = last_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               sel_d   = winner;
               state_d = BUSY;
               if (winner == OWN_D) begin
                  addr_d  = d_addr;
                  we_d    = d_we;
                  wdata_d = d_wdata;
               end else begin
                  addr_d  = i_addr;
                  we_d    = 1'b0;
               end
            end
         end
         BUSY: begin
            // mem_ack on the limit edge wins over the timeout (timeout already excludes it)
            if (mem_ack || timeout) begin
               state_d = DONE;
               last_d  = sel_q;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= OWN_I;
         last_q  <= OWN_D;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Strobes decode straight from state so reset drops them asynchronously
   assign mem_req   = (state_q == BUSY);
   assign mem_we    = mem_req && we_q;
   assign i_done    = (state_q == DONE) && (sel_q == OWN_I);
   assign d_done    = (state_q == DONE) && (sel_q == OWN_D);
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign sel       = sel_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: round-robin DUT and FIXED_PRI=1 DUT share all inputs; timeout cases under ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_req = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic          mem_ack = 1'b0;

   logic          i_done, d_done, mem_req, mem_we, sel;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          f_i_done, f_d_done, f_mem_req, f_mem_we, f_sel;
   logic [AW-1:0] f_mem_addr;
   logic [DW-1:0] f_mem_wdata;
`ifdef ARB_TIMEOUT_EN
   logic          err, f_err;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(AW), .DW(DW), .FIXED_PRI(0), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack),
`ifdef ARB_TIMEOUT_EN
      .err(err),
`endif
      .sel(sel)
   );

   mem_port_arbiter #(.AW(AW), .DW(DW), .FIXED_PRI(1), .TIMEOUT_CYC(16)) dut_fix (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_done(f_i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(f_d_done),
      .mem_req(f_mem_req), .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
      .mem_ack(mem_ack),
`ifdef ARB_TIMEOUT_EN
      .err(f_err),
`endif
      .sel(f_sel)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are then sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Main-DUT one-hot/exclusivity of strobes, checked every cycle it is sampled.
   task automatic chk_excl(input string tag);
      chk(tag, 64'(int'(i_done) + int'(d_done) + int'(mem_req) <= 1), 64'd1);
   endtask

   initial begin
      logic exp_sel;
      logic [AW-1:0] exp_addr;

      // ---- reset ----
      tick();
      chk("rst_mem_req_low", 64'(mem_req), 64'd0);
      do_reset();
      chk("rst_mem_req", 64'(mem_req), 64'd0);
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_dones", 64'({i_done, d_done}), 64'd0);
      chk("rst_sel", 64'(sel), 64'd0);

      // ---- single I fetch: req at edge 0, ack at edge 3 ----
      i_req = 1'b1; i_addr = 32'h0040_0000;
      tick();                                        // cycle 1
      chk("ifetch_c1_req", 64'(mem_req), 64'd1);
      chk("ifetch_addr", 64'(mem_addr), 64'h0040_0000);
      chk("ifetch_we", 64'(mem_we), 64'd0);
      chk("ifetch_sel", 64'(sel), 64'd0);
      tick();                                        // cycle 2
      chk("ifetch_c2_req", 64'(mem_req), 64'd1);
      tick();                                        // cycle 3
      chk("ifetch_c3_req", 64'(mem_req), 64'd1);
      chk("ifetch_c3_nodone", 64'(i_done), 64'd0);
      mem_ack = 1'b1;
      tick();                                        // cycle 4
      mem_ack = 1'b0; i_req = 1'b0;
      chk("ifetch_c4_idone", 64'(i_done), 64'd1);
      chk("ifetch_c4_ddone", 64'(d_done), 64'd0);
      chk("ifetch_c4_req", 64'(mem_req), 64'd0);
      tick();                                        // cycle 5 IDLE
      chk("ifetch_c5_idone", 64'(i_done), 64'd0);
      chk("ifetch_c5_req", 64'(mem_req), 64'd0);

      // ---- mem_ack outside BUSY ignored ----
      mem_ack = 1'b1;
      tick();
      tick();
      mem_ack = 1'b0;
      chk("stray_ack_req", 64'(mem_req), 64'd0);
      chk("stray_ack_done", 64'({i_done, d_done}), 64'd0);

      // ---- tie: both held, RR alternates I,D,I,D; fixed DUT always D ----
      do_reset();
      i_req = 1'b1; i_addr = 32'h0000_1000;
      d_req = 1'b1; d_addr = 32'h2000_0000; d_we = 1'b0; d_wdata = 32'h1234_5678;
      for (int g = 0; g < 4; g++) begin
         exp_sel  = (g % 2 == 0) ? OWN_I : OWN_D;
         exp_addr = (g % 2 == 0) ? 32'h0000_1000 : 32'h2000_0000;
         tick();                                     // BUSY
         chk($sformatf("tie%0d_sel", g), 64'(sel), 64'(exp_sel));
         chk($sformatf("tie%0d_addr", g), 64'(mem_addr), 64'(exp_addr));
         chk($sformatf("tie%0d_fix_sel", g), 64'(f_sel), 64'd1);
         chk($sformatf("tie%0d_fix_req", g), 64'(f_mem_req), 64'd1);
         mem_ack = 1'b1;
         tick();                                     // DONE
         mem_ack = 1'b0;
         chk($sformatf("tie%0d_done", g), 64'({i_done, d_done}),
             (exp_sel == OWN_I) ? 64'b10 : 64'b01);
         chk($sformatf("tie%0d_fix_done", g), 64'({f_i_done, f_d_done}), 64'b01);
         chk_excl($sformatf("tie%0d_excl", g));
         tick();                                     // IDLE
      end
      i_req = 1'b0; d_req = 1'b0;
      tick();

      // ---- store latch: inputs change mid-BUSY, req dropped ----
      do_reset();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0004; d_wdata = 32'hDEAD_BEEF;
      tick();
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h5555_5555; d_wdata = 32'h0BAD_F00D;
      chk("st_sel", 64'(sel), 64'd1);
      tick();
      chk("st_req", 64'(mem_req), 64'd1);
      chk("st_we_hold", 64'(mem_we), 64'd1);
      chk("st_addr_hold", 64'(mem_addr), 64'h1001_0004);
      chk("st_wdata_hold", 64'(mem_wdata), 64'hDEAD_BEEF);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("st_ddone", 64'(d_done), 64'd1);
      chk("st_idone", 64'(i_done), 64'd0);
      tick();
      chk("st_ddone_once", 64'(d_done), 64'd0);
      tick();
      chk("st_idle_sel_hold", 64'(sel), 64'd1);

      // ---- I fetch after store leaves wdata unchanged, we=0 ----
      i_req = 1'b1; i_addr = 32'h0040_0010;
      tick();
      chk("i_after_st_sel", 64'(sel), 64'd0);
      chk("i_after_st_we", 64'(mem_we), 64'd0);
      chk("i_after_st_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0; i_req = 1'b0;
      tick();

      // ---- reset mid-BUSY ----
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000_0000;
      tick();                                        // cycle 1 BUSY, sel=D
      chk("rmb_c1_req", 64'(mem_req), 64'd1);
      @(negedge clk);                                // mid cycle 1 -> into cycle 2
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rmb_async_req", 64'(mem_req), 64'd0);
      chk("rmb_sel", 64'(sel), 64'd0);
      d_req = 1'b0;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("rmb_no_done", 64'({i_done, d_done}), 64'd0);
      rst_n = 1'b1;
      tick();
      chk("rmb_after_done", 64'({i_done, d_done, mem_req}), 64'd0);

`ifdef ARB_TIMEOUT_EN
      // ---- timeout: no ack, done+err in cycle 17 ----
      do_reset();
      i_req = 1'b1; i_addr = 32'h0040_0100;
      for (int c = 1; c <= 16; c++) begin
         tick();
         if (c == 1) i_req = 1'b0;
         chk($sformatf("to_c%0d_req", c), 64'(mem_req), 64'd1);
         chk($sformatf("to_c%0d_err", c), 64'(err), 64'd0);
      end
      tick();                                        // cycle 17
      chk("to_c17_done", 64'(i_done), 64'd1);
      chk("to_c17_err", 64'(err), 64'd1);
      chk("to_c17_req", 64'(mem_req), 64'd0);
      tick();
      chk("to_c18_err", 64'(err), 64'd0);

      // ---- ack exactly at the limit edge: normal completion ----
      do_reset();
      i_req = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         tick();
         if (c == 1) i_req = 1'b0;
         if (c == 16) mem_ack = 1'b1;
      end
      tick();                                        // cycle 17
      mem_ack = 1'b0;
      chk("tolim_done", 64'(i_done), 64'd1);
      chk("tolim_err", 64'(err), 64'd0);
      tick();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
